// File: rtl/dds_ramp_gen.sv
// rtl/dds_ramp_gen.sv - programmable ramp/sweep word generator for the DDS core
//
// Steps a sweep word from a start value toward an end value in fixed increments,
// holding each value for a programmable dwell. Supports one-shot, sawtooth and
// triangle sweeps. All parameters are taken from shadow registers loaded on
// param_wen; the live ramp_* inputs never steer the sweep directly.
//
// Ports:
//   clk          DDS/DAC clock, rising edge
//   rstn         synchronous active-low reset
//   param_wen    load strobe for all ramp_* shadow registers
//   ramp_start   sweep start value
//   ramp_end     sweep end value
//   ramp_step    unsigned step magnitude
//   ramp_pulse   dwell in clk cycles per step (0 behaves as 1)
//   ramp_mode    0/3 one-shot, 1 sawtooth, 2 triangle
//   en           1 runs, 0 pauses (RUN) or re-arms (DONE)
//   ramp_word    current sweep value
//   ramp_tick    one-cycle pulse on every step or wrap
//   ramp_busy    high while running
//   ramp_done    high once a one-shot sweep reaches its endpoint

module dds_ramp_gen #(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  param_wen,
    input  logic [WORD_WIDTH-1:0] ramp_start,
    input  logic [WORD_WIDTH-1:0] ramp_end,
    input  logic [WORD_WIDTH-1:0] ramp_step,
    input  logic [CNT_WIDTH-1:0]  ramp_pulse,
    input  logic [1:0]            ramp_mode,
    input  logic                  en,
    output logic [WORD_WIDTH-1:0] ramp_word,
    output logic                  ramp_tick,
    output logic                  ramp_busy,
    output logic                  ramp_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SAW = 2'd1;
    localparam logic [1:0] MODE_TRI = 2'd2;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] start_q, start_d;
    logic [WORD_WIDTH-1:0] end_q, end_d;
    logic [WORD_WIDTH-1:0] step_q, step_d;
    logic [CNT_WIDTH-1:0]  pulse_q, pulse_d;
    logic [1:0]            mode_q, mode_d;
    logic                  dir_up_q, dir_up_d;   // 1: word moves upward
    logic                  ret_q, ret_d;         // triangle return leg, target is start
    logic                  wrap_q, wrap_d;       // sawtooth endpoint hit, next step reloads start
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  tick_q, tick_d;

    logic [CNT_WIDTH-1:0]  term_cnt;
    logic [WORD_WIDTH-1:0] target;
    logic [WORD_WIDTH-1:0] rem;
    logic                  reached;
    logic [WORD_WIDTH-1:0] next_word;

    // A zero dwell is treated as one cycle per step.
    assign term_cnt = (pulse_q == '0) ? '0 : pulse_q - CNT_WIDTH'(1);

    // The word always lies between the current target and where the leg began,
    // so the distance below never underflows. Clamping to the target when the
    // remaining distance fits within one step keeps the word from wrapping.
    assign target    = ret_q ? start_q : end_q;
    assign rem       = dir_up_q ? (target - word_q) : (word_q - target);
    assign reached   = (rem <= step_q);
    assign next_word = reached  ? target :
                       dir_up_q ? (word_q + step_q) : (word_q - step_q);

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        end_d    = end_q;
        step_d   = step_q;
        pulse_d  = pulse_q;
        mode_d   = mode_q;
        dir_up_d = dir_up_q;
        ret_d    = ret_q;
        wrap_d   = wrap_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        tick_d   = 1'b0;

        if (param_wen) begin
            start_d  = ramp_start;
            end_d    = ramp_end;
            step_d   = ramp_step;
            pulse_d  = ramp_pulse;
            mode_d   = ramp_mode;
            state_d  = S_IDLE;
            word_d   = ramp_start;
            cnt_d    = '0;
            dir_up_d = (ramp_end >= ramp_start);
            ret_d    = 1'b0;
            wrap_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Re-arm the sweep from the shadow registers each idle cycle.
                    word_d   = start_q;
                    cnt_d    = '0;
                    dir_up_d = (end_q >= start_q);
                    ret_d    = 1'b0;
                    wrap_d   = 1'b0;
                    if (en) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        if (cnt_q == term_cnt) begin
                            cnt_d  = '0;
                            tick_d = 1'b1;
                            if (wrap_q) begin
                                word_d = start_q;
                                wrap_d = 1'b0;
                            end else begin
                                word_d = next_word;
                                if (reached) begin
                                    if (mode_q == MODE_SAW) begin
                                        wrap_d = 1'b1;
                                    end else if (mode_q == MODE_TRI) begin
                                        dir_up_d = ~dir_up_q;
                                        ret_d    = ~ret_q;
                                    end else begin
                                        state_d = S_DONE;
                                    end
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!en) begin
                        state_d = S_IDLE;
                        word_d  = start_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            start_q  <= '0;
            end_q    <= '0;
            step_q   <= '0;
            pulse_q  <= '0;
            mode_q   <= '0;
            dir_up_q <= 1'b1;
            ret_q    <= 1'b0;
            wrap_q   <= 1'b0;
            cnt_q    <= '0;
            word_q   <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            end_q    <= end_d;
            step_q   <= step_d;
            pulse_q  <= pulse_d;
            mode_q   <= mode_d;
            dir_up_q <= dir_up_d;
            ret_q    <= ret_d;
            wrap_q   <= wrap_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            tick_q   <= tick_d;
        end
    end

    assign ramp_word = word_q;
    assign ramp_tick = tick_q;
    assign ramp_busy = (state_q == S_RUN);
    assign ramp_done = (state_q == S_DONE);

endmodule

// File: tb/tb_dds_ramp_gen.sv
// tb/tb_dds_ramp_gen.sv - self-checking bench for dds_ramp_gen
module tb_dds_ramp_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        param_wen;
    logic [31:0] ramp_start, ramp_end, ramp_step, ramp_pulse;
    logic [1:0]  ramp_mode;
    logic        en;
    logic [31:0] ramp_word;
    logic        ramp_tick, ramp_busy, ramp_done;

    always #5 clk = ~clk;

    dds_ramp_gen #(.WORD_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .param_wen  (param_wen),
        .ramp_start (ramp_start),
        .ramp_end   (ramp_end),
        .ramp_step  (ramp_step),
        .ramp_pulse (ramp_pulse),
        .ramp_mode  (ramp_mode),
        .en         (en),
        .ramp_word  (ramp_word),
        .ramp_tick  (ramp_tick),
        .ramp_busy  (ramp_busy),
        .ramp_done  (ramp_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole sweep is precomputed as a list of words
    // (the "path"); each dwell period simply advances an index into it.
    logic [31:0] path[$];
    bit          m_valid = 1'b0;
    bit          m_const;
    int          m_idx, m_cnt, m_state;     // state: 0 idle, 1 run, 2 done
    logic [31:0] m_word, m_s, m_e, m_st, m_p;
    logic [1:0]  m_mode;
    logic        m_tick;

    function automatic longint lw(input logic [31:0] v);
        return longint'({32'd0, v});
    endfunction

    function automatic void add_leg(input longint a, input longint b, input longint st);
        longint cur, rem;
        cur = a;
        do begin
            rem = (b >= cur) ? b - cur : cur - b;
            if (rem > st) cur = (b >= cur) ? cur + st : cur - st;
            else          cur = b;
            path.push_back(32'(cur));
        end while (cur != b);
    endfunction

    function automatic void build_path(input logic [31:0] s, e, st, input logic [1:0] m);
        path.delete();
        m_const = (st == 0) && (s != e);
        path.push_back(s);
        if (!m_const) begin
            add_leg(lw(s), lw(e), lw(st));
            if (m == 2'd2) add_leg(lw(e), lw(s), lw(st));
        end
    endfunction

    always @(posedge clk) begin
        int n, per;
        if (!rstn) begin
            m_valid = 1'b1;
            m_s = 0; m_e = 0; m_st = 0; m_p = 0; m_mode = 0;
            build_path(0, 0, 0, 0);
            m_state = 0; m_word = 0; m_tick = 0; m_cnt = 0; m_idx = 0;
        end else if (param_wen) begin
            m_s = ramp_start; m_e = ramp_end; m_st = ramp_step;
            m_p = ramp_pulse; m_mode = ramp_mode;
            build_path(m_s, m_e, m_st, m_mode);
            m_state = 0; m_word = m_s; m_tick = 0; m_cnt = 0; m_idx = 0;
        end else begin
            m_tick = 0;
            per = (m_p == 0) ? 1 : int'(m_p);
            case (m_state)
                0: begin
                    m_word = m_s; m_idx = 0; m_cnt = 0;
                    if (en) m_state = 1;
                end
                1: if (en) begin
                    m_cnt++;
                    if (m_cnt == per) begin
                        m_cnt  = 0;
                        m_tick = 1;
                        if (!m_const) begin
                            n = m_idx + 1;
                            if (n == path.size()) n = (m_mode == 2'd1) ? 0 : 1;
                            m_idx  = n;
                            m_word = path[n];
                            if ((m_mode == 2'd0 || m_mode == 2'd3) && n == path.size() - 1)
                                m_state = 2;
                        end
                    end
                end
                default: if (!en) begin
                    m_state = 0; m_word = m_s;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_word", ramp_word, m_word);
            check("model_tick", 32'(ramp_tick), 32'(m_tick));
            check("model_busy", 32'(ramp_busy), 32'(m_state == 1));
            check("model_done", 32'(ramp_done), 32'(m_state == 2));
        end
    end

    typedef struct {
        logic [31:0] s, e, st, p;
        logic [1:0]  m;
        int          n;
        logic [31:0] w[6];
        bit          done;
    } vec_t;

    vec_t vecs[9];

    task automatic load(input logic [31:0] s, e, st, p, input logic [1:0] m);
        ramp_start = s; ramp_end = e; ramp_step = st; ramp_pulse = p; ramp_mode = m;
        param_wen = 1'b1;
        @(negedge clk);
        param_wen = 1'b0;
        check("load_word", ramp_word, s);
        check("load_busy", 32'(ramp_busy), 32'd0);
        check("load_done", 32'(ramp_done), 32'd0);
    endtask

    task automatic rand_load();
        logic [31:0] s, st, p;
        logic [1:0]  m;
        longint      le;
        int          span;
        s = $urandom;
        if ($urandom_range(0, 3) == 0)      s = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        else if ($urandom_range(0, 3) == 0) s = 32'($urandom_range(0, 255));
        span = int'($urandom_range(0, 400));
        le = ($urandom_range(0, 1) == 1) ? lw(s) + span : lw(s) - span;
        if (le < 0) le = 0;
        if (le > 64'hFFFF_FFFF) le = 64'hFFFF_FFFF;
        st = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100));
        p  = 32'($urandom_range(0, 4));
        m  = 2'($urandom_range(0, 3));
        load(s, 32'(le), st, p, m);
    endtask

    initial begin
        int per;
        rstn = 1'b0; param_wen = 1'b0; en = 1'b0;
        ramp_start = 0; ramp_end = 0; ramp_step = 0; ramp_pulse = 0; ramp_mode = 0;

        vecs[0] = '{32'd100, 32'd130, 32'd10, 32'd3, 2'd0, 3,
                    '{32'd110, 32'd120, 32'd130, 32'd0, 32'd0, 32'd0}, 1'b1};
        vecs[1] = '{32'd0, 32'd25, 32'd10, 32'd1, 2'd0, 3,
                    '{32'd10, 32'd20, 32'd25, 32'd0, 32'd0, 32'd0}, 1'b1};
        vecs[2] = '{32'd1000, 32'd970, 32'd15, 32'd1, 2'd0, 2,
                    '{32'd985, 32'd970, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b1};
        vecs[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd8, 32'd1, 2'd1, 6,
                    '{32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_FFF0,
                      32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_FFF0}, 1'b0};
        vecs[4] = '{32'd0, 32'd20, 32'd10, 32'd2, 2'd2, 6,
                    '{32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20}, 1'b0};
        vecs[5] = '{32'd5, 32'd7, 32'd1, 32'd0, 2'd0, 2,
                    '{32'd6, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b1};
        vecs[6] = '{32'd42, 32'd42, 32'd3, 32'd2, 2'd0, 1,
                    '{32'd42, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 1'b1};
        vecs[7] = '{32'd50, 32'd40, 32'd4, 32'd1, 2'd3, 3,
                    '{32'd46, 32'd42, 32'd40, 32'd0, 32'd0, 32'd0}, 1'b1};
        vecs[8] = '{32'd3, 32'd9, 32'd0, 32'd2, 2'd0, 3,
                    '{32'd3, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0}, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_word", ramp_word, 32'd0);
        check("rst_tick", 32'(ramp_tick), 32'd0);
        check("rst_busy", 32'(ramp_busy), 32'd0);
        check("rst_done", 32'(ramp_done), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Directed vectors
        foreach (vecs[i]) begin
            en = 1'b0;
            load(vecs[i].s, vecs[i].e, vecs[i].st, vecs[i].p, vecs[i].m);
            en = 1'b1;
            @(negedge clk);
            check("vec_busy_start", 32'(ramp_busy), 32'd1);
            check("vec_word_start", ramp_word, vecs[i].s);
            per = (vecs[i].p == 0) ? 1 : int'(vecs[i].p);
            for (int j = 0; j < vecs[i].n; j++) begin
                repeat (per - 1) begin
                    @(negedge clk);
                    check("vec_tick_idle", 32'(ramp_tick), 32'd0);
                end
                @(negedge clk);
                check("vec_step_word", ramp_word, vecs[i].w[j]);
                check("vec_step_tick", 32'(ramp_tick), 32'd1);
            end
            check("vec_done", 32'(ramp_done), 32'(vecs[i].done));
            check("vec_busy", 32'(ramp_busy), 32'(!vecs[i].done));
            if (vecs[i].done) begin
                repeat (2) @(negedge clk);
                check("vec_hold_word", ramp_word, vecs[i].e);
                check("vec_hold_done", 32'(ramp_done), 32'd1);
                en = 1'b0;
                @(negedge clk);
                check("vec_rearm_done", 32'(ramp_done), 32'd0);
                check("vec_rearm_word", ramp_word, vecs[i].s);
            end
            en = 1'b0;
        end

        // Pause on the terminal-count cycle of the first dwell
        load(32'd100, 32'd130, 32'd10, 32'd3, 2'd0);
        en = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("pause_word", ramp_word, 32'd100);
            check("pause_busy", 32'(ramp_busy), 32'd1);
            check("pause_tick", 32'(ramp_tick), 32'd0);
        end
        en = 1'b1;
        @(negedge clk);
        check("resume_word", ramp_word, 32'd110);
        check("resume_tick", 32'(ramp_tick), 32'd1);

        // Reset mid-sweep
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_word", ramp_word, 32'd0);
        check("midrst_busy", 32'(ramp_busy), 32'd0);
        check("midrst_done", 32'(ramp_done), 32'd0);
        check("midrst_tick", 32'(ramp_tick), 32'd0);
        rstn = 1'b1;
        en = 1'b0;
        @(negedge clk);

        // Reload mid-sweep with en held high
        load(32'd100, 32'd130, 32'd10, 32'd3, 2'd0);
        en = 1'b1;
        repeat (5) @(negedge clk);
        load(32'd500, 32'd600, 32'd50, 32'd2, 2'd0);
        @(negedge clk);
        check("reload_busy", 32'(ramp_busy), 32'd1);
        check("reload_word", ramp_word, 32'd500);
        repeat (2) @(negedge clk);
        check("reload_step", ramp_word, 32'd550);
        check("reload_tick", 32'(ramp_tick), 32'd1);

        // Randomized sweeps checked by the reference model
        for (int c = 0; c < 12; c++) begin
            en = 1'($urandom_range(0, 1));
            rand_load();
            for (int k = 0; k < 250; k++) begin
                en = ($urandom_range(0, 99) < 85);
                if ($urandom_range(0, 299) == 0) begin
                    rstn = 1'b0;
                    @(negedge clk);
                    rstn = 1'b1;
                end else if ($urandom_range(0, 149) == 0) begin
                    rand_load();
                end else begin
                    @(negedge clk);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
